uart_tx_sequencer: RTL

- Frame controller for the UART transmit shift datapath.
- Buffers host bytes in a small FIFO and steps one frame per byte through START, DATA, optional PARITY and STOP slots, one slot per baud tick.
- Drives the datapath control bundle: start/stop slot flags, the parity slot/value pair, the interim-data select and the holding-register byte.
- Sits between the host register interface and the transmit datapath, in the system clock domain.

---
 rtl/uart_tx_sequencer_if.sv | 36 +++
 rtl/uart_tx_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer_if.sv
// Purpose: host-write, frame-config, datapath-control and status bundle of uart_tx_sequencer.
// Latency: pure wiring, no state.
// Backpressure: wr_valid/wr_ready handshake on the host side; control outputs are unthrottled.
// Ports: wr_data/wr_valid/wr_ready host byte push; par_en/par_odd/two_stop frame config;
//        ctl_start/ctl_stop/ctl_parity/ctl_intt/ctl_thr datapath control; busy/tx_done/fifo_count status.
// Modports: slave = sequencer side, master = host/datapath side.
interface uart_tx_sequencer_if #(
    parameter int AW = 2
);
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
    logic        ctl_start;
    logic        ctl_stop;
    logic [1:0]  ctl_parity;
    logic        ctl_intt;
    logic [7:0]  ctl_thr;
    logic        busy;
    logic        tx_done;
    logic [AW:0] fifo_count;

    modport slave (
        input  wr_data, wr_valid, par_en, par_odd, two_stop,
        output wr_ready, ctl_start, ctl_stop, ctl_parity, ctl_intt, ctl_thr,
               busy, tx_done, fifo_count
    );

    modport master (
        output wr_data, wr_valid, par_en, par_odd, two_stop,
        input  wr_ready, ctl_start, ctl_stop, ctl_parity, ctl_intt, ctl_thr,
               busy, tx_done, fifo_count
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Purpose: UART transmit frame controller; buffers host bytes and steps START/DATA/PARITY/STOP slots per baud tick.
// Latency: control outputs are registered, valid 1 clk after the qualifying baud_tick.
// Backpressure: wr_ready drops when the FIFO is full, unless a launch pop frees an entry in the same clk.
// Ports: clk, rst_n (async active-low), baud_tick (1-clk pulse per bit period),
//        tx_if (slave modport): host push, frame config, datapath control bundle, busy/tx_done/fifo_count.
module uart_tx_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    uart_tx_sequencer_if.slave   tx_if
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // FIFO storage and pointers
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Frame state
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          cfg_par_en_q, cfg_par_en_d;
    logic          cfg_par_odd_q, cfg_par_odd_d;
    logic          cfg_two_stop_q, cfg_two_stop_d;

    // Registered control/status outputs
    logic          ctl_start_q, ctl_start_d;
    logic          ctl_stop_q, ctl_stop_d;
    logic [1:0]    ctl_parity_q, ctl_parity_d;
    logic          ctl_intt_q, ctl_intt_d;
    logic [7:0]    ctl_thr_q, ctl_thr_d;
    logic          busy_q, busy_d;
    logic          tx_done_q, tx_done_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          at_last_stop;
    logic          launch;
    logic          push;
    logic          wr_ready;
    logic          pval;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // The final stop slot doubles as the launch point so consecutive frames
    // are emitted without an idle slot between them.
    assign at_last_stop = ((state_q == S_STOP1) && !cfg_two_stop_q) || (state_q == S_STOP2);
    assign launch       = baud_tick && !fifo_empty && ((state_q == S_IDLE) || at_last_stop);

    // A launch pop in the same clk frees an entry, so a full FIFO still accepts.
    assign wr_ready = !fifo_full || launch;
    assign push     = tx_if.wr_valid && wr_ready;

    // ---------------------------------------------------------------
    // FIFO bookkeeping
    // ---------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (launch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, launch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_if.wr_data;
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM: next state plus next registered outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        bit_idx_d      = bit_idx_q;
        cfg_par_en_d   = cfg_par_en_q;
        cfg_par_odd_d  = cfg_par_odd_q;
        cfg_two_stop_d = cfg_two_stop_q;
        ctl_thr_d      = ctl_thr_q;
        tx_done_d      = 1'b0;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
                S_DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = cfg_par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP1;
                end
                S_STOP1: begin
                    if (cfg_two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d   = launch ? S_START : S_IDLE;
                        tx_done_d = 1'b1;
                    end
                end
                S_STOP2: begin
                    state_d   = launch ? S_START : S_IDLE;
                    tx_done_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Byte and config are captured together so the whole frame is self-consistent.
        if (launch) begin
            ctl_thr_d      = mem_q[rd_ptr_q];
            cfg_par_en_d   = tx_if.par_en;
            cfg_par_odd_d  = tx_if.par_odd;
            cfg_two_stop_d = tx_if.two_stop;
        end

        pval = cfg_par_odd_d ? ~^ctl_thr_d : ^ctl_thr_d;

        // Outputs are decoded from the next state so they land 1 clk after the tick.
        ctl_start_d  = (state_d == S_START);
        ctl_stop_d   = (state_d == S_IDLE) || (state_d == S_STOP1) || (state_d == S_STOP2);
        ctl_intt_d   = (state_d == S_DATA) && (bit_idx_d != 3'd0);
        ctl_parity_d = (state_d == S_PARITY) ? {pval, 1'b1} : 2'b00;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= S_IDLE;
            bit_idx_q      <= 3'd0;
            cfg_par_en_q   <= 1'b0;
            cfg_par_odd_q  <= 1'b0;
            cfg_two_stop_q <= 1'b0;
            ctl_start_q    <= 1'b0;
            ctl_stop_q     <= 1'b1;
            ctl_parity_q   <= 2'b00;
            ctl_intt_q     <= 1'b0;
            ctl_thr_q      <= 8'h00;
            busy_q         <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            bit_idx_q      <= bit_idx_d;
            cfg_par_en_q   <= cfg_par_en_d;
            cfg_par_odd_q  <= cfg_par_odd_d;
            cfg_two_stop_q <= cfg_two_stop_d;
            ctl_start_q    <= ctl_start_d;
            ctl_stop_q     <= ctl_stop_d;
            ctl_parity_q   <= ctl_parity_d;
            ctl_intt_q     <= ctl_intt_d;
            ctl_thr_q      <= ctl_thr_d;
            busy_q         <= busy_d;
            tx_done_q      <= tx_done_d;
        end
    end

    assign tx_if.wr_ready   = wr_ready;
    assign tx_if.ctl_start  = ctl_start_q;
    assign tx_if.ctl_stop   = ctl_stop_q;
    assign tx_if.ctl_parity = ctl_parity_q;
    assign tx_if.ctl_intt   = ctl_intt_q;
    assign tx_if.ctl_thr    = ctl_thr_q;
    assign tx_if.busy       = busy_q;
    assign tx_if.tx_done    = tx_done_q;
    assign tx_if.fifo_count = count_q;

endmodule
